segment_encoder: RTL
====================

# segment_encoder

Inverse of the 7-segment decoder: samples an 8-bit segment bus (bit 0 = top, clockwise 1–5, bit 6 = middle, bit 7 = dot) and recovers the 4-bit digit code that would have produced it. It requires the pattern to be stable for a programmable number of cycles before reporting it. Each stable pattern is delivered once over a valid/ready handshake, so the downstream logic can read back what the display is showing.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical samples required before a pattern is reported; legal range 1–255.
- `clk` input 1: sole clock; all logic is on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `segments` input 8: segment pattern under observation.
- `ready` input 1: consumer accepts the current result.
- `code` output 4: recovered digit code.
- `error` output 1: the reported pattern is not a legal code.
- `valid` output 1: `code` and `error` hold a result.

## Operation
- Legal map (pattern -> code):
  - 0x3F->0, 0x06->1, 0x5B->2, 0x4F->3, 0x66->4, 0x6D->5
  - 0x7D->6, 0x07->7, 0x7F->8, 0x67->9, 0x80->10
- Exact match only; no don't-care bits on input.
- 0x00 (blank) is idle. It is never reported.
- Any other pattern is reported with `code`=4'hF and `error`=1.
- A stability filter uses a registered sample `seg_q` and a counter `cnt`, saturating at `STABLE_CYCLES`-1.
  - Each edge: `seg_q`<=`segments`.
  - `cnt`<=0 if `segments`!=`seg_q`, else `cnt`+1 (saturating).
- The FSM has four states: IDLE, SETTLE, PRESENT, DONE.
- IDLE: `valid`=0.
  - Move to SETTLE when the sampled `segments` is non-zero.
  - With `STABLE_CYCLES`=1 a non-zero sample goes directly to PRESENT.
- SETTLE: count consecutive equal samples.
  - Return to IDLE if the stable value becomes 0x00.
  - When the pattern has been sampled `STABLE_CYCLES` times in a row, register `code`/`error` from it and go to PRESENT.
- PRESENT: `valid`=1.
  - `code`/`error` are frozen and `segments` is ignored.
  - Leave only on an edge where `valid`&&`ready`; then go to DONE.
- DONE: `valid`=0. The accepted pattern is held in an internal register `acc`.
  - On the first edge where `segments`!=`acc`, go to SETTLE (or IDLE if the new value is 0x00), with `cnt` restarted by the filter rule.
  - While `segments`==`acc`, remain in DONE, so no duplicate report is made.
- Blank in DONE exits to IDLE, so a later return of the same digit is reported again.

## Timing
- Reset values: `valid`=0, `code`=0, `error`=0, state=IDLE, `seg_q`=0x00, `cnt`=0, `acc`=0x00.
- Latency: pattern P is first present at rising edge k (P!=0, previous sample differs).
  - `code`/`error`/`valid`=1 are registered at edge k+`STABLE_CYCLES`-1.
  - They are visible in the cycle after that edge; there is no combinational path from `segments` to any output.
- Any change of `segments` in SETTLE before the count completes restarts the count from the new value. A glitch shorter than `STABLE_CYCLES` samples is never reported.
- Handshake:
  - Transfer occurs on an edge with `valid`=1 and `ready`=1; `valid` is 0 the next cycle.
  - `ready` while `valid`=0 has no effect.
  - `ready` may be held high permanently.
  - Outputs must not change while `valid`=1 and `ready`=0.
- Minimum spacing between two reports is `STABLE_CYCLES`+1 cycles after acceptance: one cycle in DONE to detect the change, then the settle count.
- `reset` has priority on any edge. Mid-PRESENT it drops `valid` on the next edge; the pending result is lost and not re-reported unless the filter re-qualifies it from IDLE.
- Outputs are registered; `code` keeps its last value when `valid`=0.

## Test plan
- Reset: hold `reset` 2 cycles with `segments`=0x7F -> `valid`=0, `code`=0, `error`=0 throughout.
- Sweep: `STABLE_CYCLES`=4, `ready`=1, drive each legal pattern for 6 cycles separated by 0x00.
  - Expect exactly one `valid` pulse per pattern, 4 edges after it appears.
  - Expected codes: 0x3F->0, 0x5B->2, 0x7D->6, 0x80->10; `error`=0.
- Glitch and error: drive 0x06 for 3 cycles, then 0x5B -> no report for 0x06, single report `code`=2. Then drive 0x12 stable -> `code`=15, `error`=1.
- Backpressure: drive 0x6D stable with `ready`=0 for 10 cycles.
  - `valid`=1 and `code`=5 stay constant.
  - Change `segments` to 0x07 mid-hold -> outputs unchanged.
  - Assert `ready` -> `valid` drops, then `code`=7 is reported `STABLE_CYCLES`+1 cycles later.
- No duplicate: after 0x4F is accepted, hold 0x4F for 50 cycles -> no second report. Drive 0x00 for 1 cycle, then 0x4F -> reported again with `code`=3.
- Reset mid-operation and minimum latency:
  - Assert `reset` during PRESENT -> `valid`=0 the next cycle.
  - `STABLE_CYCLES`=1: 0x66 appearing at edge k -> `valid`=1, `code`=4 after edge k.

Source files
------------

// File: rtl/segment_encoder.sv
// segment_encoder: recovers the digit code from a stable 7-segment pattern and reports it once over valid/ready
module segment_encoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] segments,
    input  logic       ready,
    output logic [3:0] code,
    output logic       error,
    output logic       valid
);
    typedef enum logic [1:0] {IDLE, SETTLE, PRESENT, DONE} state_t;

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);
    localparam bit         SINGLE  = (STABLE_CYCLES == 1);

    state_t     state_q, state_d;
    logic [7:0] seg_q, cnt_q, cnt_d, acc_q, acc_d;
    logic [3:0] code_q, code_d, dec_code;
    logic       error_q, error_d;
    logic       same, run_ok, exit_done, load;

    // the current sample completes a run of STABLE_CYCLES identical samples
    assign same   = (segments == seg_q);
    assign run_ok = SINGLE || (same && ({1'b0, cnt_q} + 9'd2 >= 9'(STABLE_CYCLES)));

    // exact-match lookup of the sampled pattern; anything unknown maps to F
    always_comb begin
        dec_code = 4'hF;
        case (segments)
            8'h3F: dec_code = 4'd0;
            8'h06: dec_code = 4'd1;
            8'h5B: dec_code = 4'd2;
            8'h4F: dec_code = 4'd3;
            8'h66: dec_code = 4'd4;
            8'h6D: dec_code = 4'd5;
            8'h7D: dec_code = 4'd6;
            8'h07: dec_code = 4'd7;
            8'h7F: dec_code = 4'd8;
            8'h67: dec_code = 4'd9;
            8'h80: dec_code = 4'd10;
            default: dec_code = 4'hF;
        endcase
    end

    // next state, result capture on qualification, and DONE exit detection
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        code_d    = code_q;
        error_d   = error_q;
        exit_done = 1'b0;
        load      = 1'b0;
        case (state_q)
            IDLE: if (segments != 8'h00) begin
                load    = run_ok;
                state_d = run_ok ? PRESENT : SETTLE;
            end
            SETTLE: if (segments == 8'h00) state_d = IDLE;
                    else if (run_ok) begin
                        load    = 1'b1;
                        state_d = PRESENT;
                    end
            PRESENT: if (ready) state_d = DONE;
            DONE: if (segments != acc_q) begin
                exit_done = 1'b1;
                state_d   = (segments == 8'h00) ? IDLE : SETTLE;
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            code_d  = dec_code;
            error_d = (dec_code == 4'hF);
            acc_d   = segments;
        end
    end

    // stability counter: restarts on a change or when leaving DONE, saturates otherwise
    always_comb begin
        cnt_d = (!same || exit_done) ? 8'd0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1);
    end

    // state, filter and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            seg_q   <= 8'h00;
            cnt_q   <= 8'd0;
            acc_q   <= 8'h00;
            code_q  <= 4'd0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            seg_q   <= segments;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            code_q  <= code_d;
            error_q <= error_d;
        end
    end

    assign valid = (state_q == PRESENT);
    assign code  = code_q;
    assign error = error_q;
endmodule
